// File: rtl/banked_data_mem_if.sv
// banked_data_mem_if: request/response channel between a load/store unit and banked_data_mem
interface banked_data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();
  localparam int BE_W = DATA_W / 8;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/banked_data_mem.sv
// banked_data_mem: byte-lane data memory with wait states, valid/ready request and registered response
module banked_data_mem #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  banked_data_mem_if.slave  bus,
  output logic              busy
);
  localparam int BE_W = DATA_W / 8;
  localparam int WL   = WAIT_CYC > 0 ? WAIT_CYC - 1 : 0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state, state_n;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept, commit, c_we, in_range;
  logic [ADDR_W-1:0] c_addr, idx;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  // with no wait states the access commits on the accept edge straight from the request
  always_comb begin
    accept   = state == IDLE && bus.req_valid;
    commit   = WAIT_CYC == 0 ? accept : (state == WAIT && cnt == 4'd0);
    c_we     = WAIT_CYC == 0 ? bus.req_we    : we_q;
    c_addr   = WAIT_CYC == 0 ? bus.req_addr  : addr_q;
    c_wdata  = WAIT_CYC == 0 ? bus.req_wdata : wdata_q;
    c_be     = WAIT_CYC == 0 ? bus.req_be    : be_q;
    in_range = 32'(c_addr) < DEPTH;
    idx      = in_range ? c_addr : '0;
    state_n  = state == IDLE ? (accept ? (WAIT_CYC == 0 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
             : (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) cnt <= 4'(WL);
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit) begin
        rdata_q <= (!c_we && in_range) ? mem[idx] : '0;
        err_q   <= !in_range;
      end
    end
  end
  always_ff @(posedge clk)
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  // a reset on the commit edge aborts the write
  always_ff @(posedge clk)
    for (int i = 0; i < BE_W; i++)
      if (!rst && commit && c_we && in_range && c_be[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = state != IDLE;
endmodule

// File: tb/tb_banked_data_mem.sv
// tb_banked_data_mem: vector table, corner sequences and random model check of banked_data_mem
module tb_banked_data_mem;
  logic clk, rst;
  logic mbusy;
  logic [2:0] a_busy, a_rdy, a_vld;
  logic [15:0] a_rd [3];
  logic [2:0] a_er;
  logic av, awe, ar;
  logic [7:0] aaddr;
  logic [15:0] awd;
  logic [1:0] abe;
  int tests = 0, fails = 0;
  banked_data_mem_if #(.DATA_W(16), .ADDR_W(8)) m(), b0(), b15(), b4();
  banked_data_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYC(1))
    u_main (.clk(clk), .rst(rst), .bus(m), .busy(mbusy));
  banked_data_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0))
    u_w0 (.clk(clk), .rst(rst), .bus(b0), .busy(a_busy[0]));
  banked_data_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(15))
    u_w15 (.clk(clk), .rst(rst), .bus(b15), .busy(a_busy[1]));
  banked_data_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(4))
    u_w4 (.clk(clk), .rst(rst), .bus(b4), .busy(a_busy[2]));
  assign {b0.req_valid, b0.req_we, b0.req_addr, b0.req_wdata, b0.req_be, b0.rsp_ready} = {av, awe, aaddr, awd, abe, ar};
  assign {b15.req_valid, b15.req_we, b15.req_addr, b15.req_wdata, b15.req_be, b15.rsp_ready} = {av, awe, aaddr, awd, abe, ar};
  assign {b4.req_valid, b4.req_we, b4.req_addr, b4.req_wdata, b4.req_be, b4.rsp_ready} = {av, awe, aaddr, awd, abe, ar};
  assign a_rdy = {b4.req_ready, b15.req_ready, b0.req_ready};
  assign a_vld = {b4.rsp_valid, b15.rsp_valid, b0.rsp_valid};
  assign a_er  = {b4.rsp_err, b15.rsp_err, b0.rsp_err};
  assign a_rd[0] = b0.rsp_rdata;
  assign a_rd[1] = b15.rsp_rdata;
  assign a_rd[2] = b4.rsp_rdata;
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rd;
    logic        err;
  } vec_t;
  vec_t tv [16];
  logic [15:0] model [256];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  // one transaction on the WAIT_CYC=1 instance; called and returns at a falling edge
  task automatic mtxn(input logic we, input logic [7:0] a, input logic [15:0] wd, input logic [1:0] be,
                      input int hold, output logic [15:0] rd, output logic err, output int lat);
    int n;
    m.req_valid = 1'b1; m.req_we = we; m.req_addr = a; m.req_wdata = wd; m.req_be = be; m.rsp_ready = 1'b0;
    n = 0;
    while (!m.req_ready && n < 50) begin @(negedge clk); n++; end
    chk("m_accept", 32'(m.req_ready), 32'd1);
    @(negedge clk);
    m.req_valid = 1'b0;
    lat = 1;
    while (!m.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    rd = m.rsp_rdata; err = m.rsp_err;
    repeat (hold) begin
      @(negedge clk);
      chk("m_rsp_hold", 32'({m.rsp_valid, m.req_ready, m.rsp_err, m.rsp_rdata}), 32'({1'b1, 1'b0, err, rd}));
    end
    m.rsp_ready = 1'b1;
    @(negedge clk);
    m.rsp_ready = 1'b0;
  endtask
  task automatic atxn(input int k, input logic we, input logic [7:0] a, input logic [15:0] wd, input logic [1:0] be,
                      output logic [15:0] rd, output logic err);
    int n;
    av = 1'b1; awe = we; aaddr = a; awd = wd; abe = be; ar = 1'b0;
    n = 0;
    while (!a_rdy[k] && n < 60) begin @(negedge clk); n++; end
    chk("a_accept", 32'(a_rdy[k]), 32'd1);
    @(negedge clk);
    av = 1'b0;
    n = 0;
    while (!a_vld[k] && n < 60) begin @(negedge clk); n++; end
    chk("a_rsp", 32'(a_vld[k]), 32'd1);
    rd = a_rd[k]; err = a_er[k];
    ar = 1'b1;
    @(negedge clk);
    ar = 1'b0;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  // accept-to-valid latency and busy span with a two-cycle response hold
  task automatic lat_test(input int k, input int w);
    int lat, bc;
    pulse_rst();
    av = 1'b1; awe = 1'b0; aaddr = 8'h01; awd = '0; abe = '0; ar = 1'b0;
    @(negedge clk);
    av = 1'b0;
    lat = 1; bc = int'(a_busy[k]);
    while (!a_vld[k] && lat < 40) begin @(negedge clk); lat++; bc += int'(a_busy[k]); end
    repeat (2) begin @(negedge clk); bc += int'(a_busy[k]); end
    ar = 1'b1;
    @(negedge clk);
    bc += int'(a_busy[k]);
    ar = 1'b0;
    chk($sformatf("lat_w%0d", w), 32'(lat), 32'(w + 1));
    chk($sformatf("busy_w%0d", w), 32'(bc), 32'(w + 3));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [15:0] rd, exp_rd, mask;
    logic err;
    int lat;
    logic we;
    logic [7:0] a;
    logic [15:0] wd;
    logic [1:0] be;
    tv[0]  = '{1'b1, 8'h09, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
    tv[1]  = '{1'b0, 8'h09, 16'h0000, 2'b00, 16'hBEEF, 1'b0};
    tv[2]  = '{1'b1, 8'h10, 16'h1234, 2'b11, 16'h0000, 1'b0};
    tv[3]  = '{1'b1, 8'h10, 16'hABCD, 2'b01, 16'h0000, 1'b0};
    tv[4]  = '{1'b0, 8'h10, 16'h0000, 2'b11, 16'h12CD, 1'b0};
    tv[5]  = '{1'b1, 8'h10, 16'hEF00, 2'b10, 16'h0000, 1'b0};
    tv[6]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'hEFCD, 1'b0};
    tv[7]  = '{1'b1, 8'h10, 16'hFFFF, 2'b00, 16'h0000, 1'b0};
    tv[8]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'hEFCD, 1'b0};
    tv[9]  = '{1'b1, 8'd199, 16'h4242, 2'b11, 16'h0000, 1'b0};
    tv[10] = '{1'b0, 8'd199, 16'h0000, 2'b00, 16'h4242, 1'b0};
    tv[11] = '{1'b1, 8'd10, 16'h0A0A, 2'b11, 16'h0000, 1'b0};
    tv[12] = '{1'b1, 8'd210, 16'h5555, 2'b11, 16'h0000, 1'b1};
    tv[13] = '{1'b0, 8'd210, 16'h0000, 2'b00, 16'h0000, 1'b1};
    tv[14] = '{1'b0, 8'd10, 16'h0000, 2'b00, 16'h0A0A, 1'b0};
    tv[15] = '{1'b0, 8'd199, 16'h0000, 2'b00, 16'h4242, 1'b0};
    clk = 1'b0; rst = 1'b1;
    m.req_valid = 1'b0; m.req_we = 1'b0; m.req_addr = '0; m.req_wdata = '0; m.req_be = '0; m.rsp_ready = 1'b0;
    av = 1'b0; awe = 1'b0; aaddr = '0; awd = '0; abe = '0; ar = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", 32'({m.req_ready, m.rsp_valid, mbusy, m.rsp_err, m.rsp_rdata}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0}));
    for (int i = 0; i < 16; i++) begin
      mtxn(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].be, i % 3, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tv[i].rd));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tv[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
    end
    // backpressure: second request held while the first response is stalled
    m.req_valid = 1'b1; m.req_we = 1'b0; m.req_addr = 8'h09; m.rsp_ready = 1'b0;
    @(negedge clk);
    m.req_addr = 8'h10;
    lat = 1;
    while (!m.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("bp_lat", 32'(lat), 32'd2);
    chk("bp_rdata", 32'(m.rsp_rdata), 32'hBEEF);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", 32'({m.rsp_valid, m.req_ready, mbusy, m.rsp_err, m.rsp_rdata}), 32'({1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF}));
    end
    m.rsp_ready = 1'b1;
    @(negedge clk);
    m.rsp_ready = 1'b0;
    chk("bp_no_b2b", 32'({mbusy, m.req_ready}), 32'({1'b0, 1'b1}));
    @(negedge clk);
    m.req_valid = 1'b0;
    chk("bp_accept2", 32'(mbusy), 32'd1);
    lat = 1;
    while (!m.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("bp2_lat", 32'(lat), 32'd2);
    chk("bp2_rdata", 32'(m.rsp_rdata), 32'hEFCD);
    m.rsp_ready = 1'b1;
    @(negedge clk);
    m.rsp_ready = 1'b0;
    // reset while a response is pending drops it
    m.req_valid = 1'b1; m.req_we = 1'b0; m.req_addr = 8'h09;
    @(negedge clk);
    m.req_valid = 1'b0;
    lat = 1;
    while (!m.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    pulse_rst();
    chk("rst_in_resp", 32'({m.rsp_valid, m.req_ready, mbusy, m.rsp_err, m.rsp_rdata}), 32'({1'b0, 1'b1, 1'b0, 1'b0, 16'h0}));
    // random traffic against a word-array model
    for (int i = 0; i < 200; i++) begin
      wd = 16'($urandom);
      mtxn(1'b1, 8'(i), wd, 2'b11, 0, rd, err, lat);
      model[i] = wd;
    end
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 230));
      wd = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      mtxn(we, a, wd, be, $urandom_range(0, 3), rd, err, lat);
      exp_rd = (!we && a < 200) ? model[a] : 16'h0;
      chk($sformatf("rnd%0d_rdata a=%0d we=%0d", i, a, we), 32'(rd), 32'(exp_rd));
      chk($sformatf("rnd%0d_err", i), 32'(err), 32'(a >= 200));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd2);
      if (we && a < 200) begin
        mask = {{8{be[1]}}, {8{be[0]}}};
        model[a] = (model[a] & ~mask) | (wd & mask);
      end
    end
    lat_test(0, 0);
    lat_test(1, 15);
    // reset during the wait states aborts the write
    pulse_rst();
    atxn(2, 1'b1, 8'h20, 16'h0001, 2'b11, rd, err);
    chk("w4_pre_err", 32'(err), 32'd0);
    pulse_rst();
    av = 1'b1; awe = 1'b1; aaddr = 8'h20; awd = 16'h7777; abe = 2'b11;
    @(negedge clk);
    av = 1'b0;
    @(negedge clk);
    pulse_rst();
    chk("w4_rst_state", 32'({a_rdy[2], a_vld[2], a_busy[2]}), 32'({1'b1, 1'b0, 1'b0}));
    atxn(2, 1'b0, 8'h20, 16'h0, 2'b00, rd, err);
    chk("w4_abort_rdata", 32'(rd), 32'h0001);
    atxn(2, 1'b1, 8'h21, 16'h3C5A, 2'b11, rd, err);
    atxn(2, 1'b0, 8'h21, 16'h0, 2'b00, rd, err);
    chk("w4_rw_rdata", 32'(rd), 32'h3C5A);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
